lab8_bit_serializer: RTL and testbench

- Parallel-to-serial stage feeding the 1101 sequence detector's serial bit input.
- Accepts WIDTH-bit words through a valid/ready handshake and shifts them out one bit per clock.
- Back-to-back words stream with no idle bit between them.
- Keeps a wrapping count of completed words for the lab bench.

---
 rtl/lab8_bit_serializer_if.sv | 34 +++
 rtl/lab8_bit_serializer.sv | 73 +++++++
 tb/tb_lab8_bit_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lab8_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for the lab8 bit serializer.
// The master side drives words in; the slave side is the serializer itself.
interface lab8_bit_serializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             d_out;
  logic             bit_valid;
  logic             word_done;
  logic [CNT_W-1:0] word_count;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  d_out,
    input  bit_valid,
    input  word_done,
    input  word_count
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output d_out,
    output bit_valid,
    output word_done,
    output word_count
  );
endinterface

// File: rtl/lab8_bit_serializer.sv
// Parallel-to-serial stage: takes WIDTH-bit words over valid/ready and emits one bit per clock,
// streaming back-to-back words without a bubble and counting completed words.
module lab8_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input logic                  clock,
  input logic                  rst,
  lab8_bit_serializer_if.slave bus
);

  localparam int unsigned CntBits = $clog2(WIDTH);

  typedef enum logic {StIdle, StShift} state_e;

  state_e             state;
  logic [WIDTH-1:0]   shreg;
  logic [CntBits-1:0] cnt;
  logic [CNT_W-1:0]   word_count;

  logic             ready;
  logic             accept;
  logic             last_bit;
  logic             out_bit;
  logic [WIDTH-1:0] shreg_next;

  always_comb begin
    last_bit = (state == StShift) && (cnt == '0);
    // Ready on the last bit lets the next word load in the same edge the current one finishes.
    ready    = (state == StIdle) || last_bit;
    accept   = bus.in_valid && ready;
    if (MSB_FIRST) begin
      out_bit    = shreg[WIDTH-1];
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      out_bit    = shreg[0];
      shreg_next = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= StIdle;
      shreg      <= '0;
      cnt        <= '0;
      word_count <= '0;
    end else begin
      if (accept) begin
        state <= StShift;
        shreg <= bus.in_data;
        cnt   <= CntBits'(WIDTH - 1);
      end else if (state == StShift) begin
        if (cnt == '0) begin
          state <= StIdle;
        end else begin
          shreg <= shreg_next;
          cnt   <= cnt - CntBits'(1);
        end
      end
      if (last_bit) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.bit_valid  = (state == StShift);
  assign bus.d_out      = (state == StShift) && out_bit;
  assign bus.word_done  = last_bit;
  assign bus.word_count = word_count;

endmodule

// File: tb/tb_lab8_bit_serializer.sv
// Scoreboard bench: one MSB-first and one LSB-first serializer; expected bits are queued at
// each accept and popped against the DUT output on every falling edge.
module tb_lab8_bit_serializer;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  lab8_bit_serializer_if #(.WIDTH(8), .CNT_W(8)) ia ();
  lab8_bit_serializer_if #(.WIDTH(8), .CNT_W(8)) ib ();

  lab8_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(8)) dut_a (
    .clock (clock),
    .rst   (rst),
    .bus   (ia)
  );

  lab8_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(8)) dut_b (
    .clock (clock),
    .rst   (rst),
    .bus   (ib)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          mon_en = 1'b0;
  bit          qa[$];
  bit          qb[$];
  logic [7:0]  cnt_a  = '0;
  logic [7:0]  cnt_b  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("a_bit_valid", ia.bit_valid, qa.size() != 0);
      chk("a_d_out", ia.d_out, (qa.size() != 0) ? qa[0] : 1'b0);
      chk("a_word_done", ia.word_done, qa.size() == 1);
      chk("a_in_ready", ia.in_ready, qa.size() <= 1);
      chk("a_word_count", ia.word_count, cnt_a);
      if (rst) begin
        qa.delete();
        cnt_a = '0;
      end else begin
        if (qa.size() == 1) cnt_a = cnt_a + 8'd1;
        if (qa.size() != 0) void'(qa.pop_front());
        if (ia.in_valid && ia.in_ready)
          for (int i = 0; i < 8; i++) qa.push_back(ia.in_data[7-i]);
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("b_bit_valid", ib.bit_valid, qb.size() != 0);
      chk("b_d_out", ib.d_out, (qb.size() != 0) ? qb[0] : 1'b0);
      chk("b_word_done", ib.word_done, qb.size() == 1);
      chk("b_in_ready", ib.in_ready, qb.size() <= 1);
      chk("b_word_count", ib.word_count, cnt_b);
      if (rst) begin
        qb.delete();
        cnt_b = '0;
      end else begin
        if (qb.size() == 1) cnt_b = cnt_b + 8'd1;
        if (qb.size() != 0) void'(qb.pop_front());
        if (ib.in_valid && ib.in_ready)
          for (int i = 0; i < 8; i++) qb.push_back(ib.in_data[i]);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input bit to_b, input logic [7:0] w);
    bit got = 1'b0;
    if (to_b) begin
      ib.in_data = w; ib.in_valid = 1'b1;
    end else begin
      ia.in_data = w; ia.in_valid = 1'b1;
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (to_b ? ib.in_ready : ia.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_timeout", got, 1'b1);
    @(posedge clock); #1;
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (qa.size() == 0 && qb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", done, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_data = '0;
    ib.in_valid = 1'b0; ib.in_data = '0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: monitor expects no bit_valid at all.
    repeat (20) @(posedge clock);
    #1;

    send(1'b0, 8'hD0);
    wait_idle();
    chk("t1_word_count", ia.word_count, 8'd1);

    send(1'b0, 8'hD0);
    send(1'b0, 8'h0D);
    wait_idle();
    chk("t2_word_count", ia.word_count, 8'd3);

    send(1'b1, 8'h0B);
    wait_idle();
    chk("t3_word_count", ib.word_count, 8'd1);

    // in_data churns every cycle with in_valid high; only the value present at ready counts.
    send(1'b0, 8'hA5);
    ia.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ia.in_data = 8'($urandom);
      @(posedge clock); #1;
    end
    ia.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ia.in_data = 8'($urandom);
      @(posedge clock); #1;
    end
    wait_idle();

    // Reset during the 4th bit of 8'hFF.
    send(1'b0, 8'hFF);
    repeat (3) @(posedge clock);
    #1;
    pulse_reset();
    chk("t4_bit_valid", ia.bit_valid, 1'b0);
    chk("t4_d_out", ia.d_out, 1'b0);
    chk("t4_in_ready", ia.in_ready, 1'b1);
    chk("t4_word_count", ia.word_count, 8'd0);
    wait_idle();

    // 256 streamed words wrap the counter back to zero.
    for (int i = 0; i < 255; i++) send(1'b0, 8'($urandom));
    wait_idle();
    chk("t5_count_255", ia.word_count, 8'd255);
    send(1'b0, 8'h5A);
    wait_idle();
    chk("t5_count_wrap", ia.word_count, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
